ram_param_clr: RTL and testbench
================================

Name: ram_param_clr

Overview:
Parametrised single-port synchronous RAM for the BitBlaster datapath. Width and depth are configurable. Read latency is selectable (0 or 1 cycles). Reset does not clear the whole array in one step; a sequential clear engine writes CLEAR_VAL to every word, one word per cycle, so the array can map to block RAM. Software can also start the same clear at run time through clear_req.

Parameters:
DATA_W, 10, data word width in bits (1..64)
ADDR_W, 10, address width in bits
DEPTH, 1024, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W
READ_LAT, 1, read latency in cycles; 0 = combinational read, 1 = registered read
CLEAR_VAL, 0, DATA_W-bit value written to every word during a clear

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  reset, asynchronous, active-high; clock clk
clear_req  input  1  one-cycle request to clear the entire array
we  input  1  write enable
re  input  1  read enable
addr  input  ADDR_W  word address
din  input  DATA_W  write data
dout  output  DATA_W  read data
rd_valid  output  1  dout holds the result of an accepted read
busy  output  1  clear in progress; accesses are ignored
err  output  1  one-cycle pulse when an accepted access has addr >= DEPTH

Behaviour:
- FSM states: CLEAR, IDLE.
- Reset (asynchronous) forces:
  - state=CLEAR, clr_ptr=0, busy=1;
  - rd_valid=0, err=0, and dout=0 when READ_LAT=1.
- Memory contents are not touched asynchronously.
- CLEAR state, one word per cycle:
  - each cycle writes mem[clr_ptr]=CLEAR_VAL, then clr_ptr increments;
  - on the cycle that writes word DEPTH-1, next state is IDLE and busy drops on that edge;
  - the clear takes exactly DEPTH cycles after reset deasserts.
- While busy=1:
  - we, re and clear_req are ignored (no write, rd_valid=0, err=0);
  - dout holds its last value.
- IDLE with clear_req=1:
  - next state is CLEAR, clr_ptr=0, busy=1 from the next cycle;
  - clear_req has priority, so a we/re in the same cycle is dropped and rd_valid/err stay 0.
- Accepted access: state=IDLE, clear_req=0, and we or re is high.
- Write: mem[addr]<=din on the edge. Out-of-range addr: no write, err=1 next cycle.
- Read, READ_LAT=1:
  - dout and rd_valid are registered and valid the cycle after re;
  - rd_valid is a one-cycle pulse per accepted read;
  - out-of-range addr gives dout=CLEAR_VAL and err=1.
- Read, READ_LAT=0:
  - dout=mem[addr] combinationally, rd_valid=re&&!busy&&!clear_req combinationally;
  - out-of-range addr gives dout=CLEAR_VAL;
  - err stays registered (next cycle) for both latencies.
- Same-cycle we and re to the same address:
  - READ_LAT=1 is read-first: the old data is returned and the new data is stored;
  - READ_LAT=0 returns the old data in that cycle.
- Back-to-back reads are accepted every cycle; there is no stall in IDLE.
- Reset asserted mid-clear or mid-access aborts the operation immediately. The clear restarts from word 0 after reset is released.
- Address wrap: clr_ptr never exceeds DEPTH-1. addr is never wrapped; out-of-range accesses are flagged, not aliased.

Test Plan:
1. Reset pulse, DEPTH=1024 -> busy=1 for exactly 1024 cycles after release; then read all words -> every dout=0x000.
2. IDLE, write addr=5 din=0x3A5, then re addr=5 (READ_LAT=1) -> next cycle dout=0x3A5, rd_valid=1 for one cycle.
3. Same cycle we=1 din=0x155, re=1, addr=7, old mem[7]=0x2AA -> dout=0x2AA; a following read of addr 7 returns 0x155.
4. clear_req together with we addr=9 din=0x0FF -> write dropped, busy=1 for 1024 cycles; then read addr 9 -> 0x000.
5. DEPTH=1000: write addr=1010 -> err=1 one cycle, no alias write to addr 1010-1000=10; read addr 1010 -> dout=CLEAR_VAL, err=1.
6. Reset asserted at clear cycle 500, released -> clr_ptr restarts at 0, busy lasts a full DEPTH cycles; READ_LAT=0 build repeats test 2 with dout valid in the same cycle.

Source files
------------

// File: rtl/ram_param_clr.sv
// Single-port synchronous RAM with a word-per-cycle clear engine that runs after reset or on request.
// The array only ever sees synchronous single-port writes, so it can still map to block RAM.
module ram_param_clr #(
    parameter int                DATA_W    = 10,
    parameter int                ADDR_W    = 10,
    parameter int                DEPTH     = 1024,
    parameter int                READ_LAT  = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] clr_ptr_reg;
    logic              busy_reg;
    logic              err_reg;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              accept;
    logic              in_range;
    logic              wr_ok;
    logic              rd_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // clear_req wins over a same-cycle access; addresses are never aliased
    assign accept   = (state_reg == IDLE) && !clear_req;
    assign in_range = {1'b0, addr} < DEPTH_W;
    assign wr_ok    = accept && we && in_range;
    assign rd_ok    = accept && re;

    // The clear engine and user writes share the one write port
    assign mem_we    = !reset && ((state_reg == CLEAR) || wr_ok);
    assign mem_addr  = (state_reg == CLEAR) ? clr_ptr_reg : addr;
    assign mem_wdata = (state_reg == CLEAR) ? CLEAR_VAL : din;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= CLEAR;
            clr_ptr_reg <= '0;
            busy_reg    <= 1'b1;
            err_reg     <= 1'b0;
        end else begin
            err_reg <= accept && (we || re) && !in_range;
            case (state_reg)
                CLEAR: begin
                    if (clr_ptr_reg == LAST_PTR) begin
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                        clr_ptr_reg <= '0;
                    end else begin
                        clr_ptr_reg <= clr_ptr_reg + 1'b1;
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state_reg   <= CLEAR;
                        clr_ptr_reg <= '0;
                        busy_reg    <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    generate
        if (READ_LAT == 1) begin : g_reg_read
            logic [DATA_W-1:0] dout_reg;
            logic              rd_valid_reg;

            // Reading mem here sees the pre-edge contents, giving read-first behaviour
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dout_reg     <= '0;
                    rd_valid_reg <= 1'b0;
                end else begin
                    rd_valid_reg <= rd_ok;
                    if (rd_ok) begin
                        dout_reg <= in_range ? mem[addr] : CLEAR_VAL;
                    end
                end
            end

            assign dout     = dout_reg;
            assign rd_valid = rd_valid_reg;
        end else begin : g_comb_read
            logic [DATA_W-1:0] rd_data;
            logic [DATA_W-1:0] hold_reg;

            assign rd_data = in_range ? mem[addr] : CLEAR_VAL;

            // Last accepted read result, presented while the clear engine owns the array
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hold_reg <= '0;
                end else if (rd_ok) begin
                    hold_reg <= rd_data;
                end
            end

            assign dout     = busy_reg ? hold_reg : rd_data;
            assign rd_valid = re && !busy_reg && !clear_req;
        end
    endgenerate

    assign busy = busy_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_ram_param_clr.sv
// Bench for ram_param_clr: a registered-read 1024-word instance and a combinational-read 1000-word
// instance share one stimulus stream and are checked against array-based reference models.
module tb_ram_param_clr;

    localparam int          D1  = 1024;
    localparam int          D0  = 1000;
    localparam logic [9:0]  CV0 = 10'h1C3;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear_req;
    logic       we;
    logic       re;
    logic [9:0] addr;
    logic [9:0] din;
    logic [9:0] dout1, dout0;
    logic       rv1, rv0, busy1, busy0, err1, err0;

    always #5 clk = ~clk;

    ram_param_clr #(.DATA_W(10), .ADDR_W(10), .DEPTH(D1), .READ_LAT(1), .CLEAR_VAL(10'h000)) dut1 (
        .clk(clk), .reset(reset), .clear_req(clear_req), .we(we), .re(re), .addr(addr), .din(din),
        .dout(dout1), .rd_valid(rv1), .busy(busy1), .err(err1)
    );

    ram_param_clr #(.DATA_W(10), .ADDR_W(10), .DEPTH(D0), .READ_LAT(0), .CLEAR_VAL(CV0)) dut0 (
        .clk(clk), .reset(reset), .clear_req(clear_req), .we(we), .re(re), .addr(addr), .din(din),
        .dout(dout0), .rd_valid(rv0), .busy(busy0), .err(err0)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: word arrays plus the expected observable outputs
    logic [9:0] m1 [D1];
    logic [9:0] m0 [D0];
    logic [9:0] exp_dout1 = '0;
    logic       exp_rv1   = 1'b0;
    logic       exp_err1  = 1'b0;
    logic       exp_err0  = 1'b0;
    logic [9:0] exp_dout0c = '0;
    logic       exp_rv0c  = 1'b0;
    logic [9:0] exp_hold0 = '0;
    logic       hold0_known = 1'b0;

    task automatic model_clear();
        for (int i = 0; i < D1; i++) m1[i] = 10'h000;
        for (int i = 0; i < D0; i++) m0[i] = CV0;
    endtask

    // Applies one IDLE-state access after a falling edge and computes what both instances must show
    task automatic drive(input logic w, input logic r, input int a, input logic [9:0] d, input logic c);
        @(negedge clk);
        we = w; re = r; addr = 10'(a); din = d; clear_req = c;
        exp_dout0c = (a < D0) ? m0[a] : CV0;
        exp_rv0c   = r && !c;
        if (c) begin
            exp_rv1  = 1'b0;
            exp_err1 = 1'b0;
            exp_err0 = 1'b0;
            model_clear();
        end else begin
            exp_rv1  = r;
            exp_err1 = (w || r) && (a >= D1);
            exp_err0 = (w || r) && (a >= D0);
            if (r) begin
                exp_dout1   = m1[a];
                exp_hold0   = exp_dout0c;
                hold0_known = 1'b1;
            end
            if (w) begin
                m1[a] = d;
                if (a < D0) m0[a] = d;
            end
        end
        #1;
    endtask

    // Runs a clear to completion with ignored stimulus; returns the edge on which each busy dropped
    task automatic run_clear(output int n1, output int n0);
        int k;
        n1 = 0; n0 = 0; k = 0;
        while ((n1 == 0 || n0 == 0) && k < 1200) begin
            k++;
            if (k <= D0) begin
                we = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
                clear_req = 1'($urandom_range(0, 1)); addr = 10'($urandom); din = 10'($urandom);
            end else begin
                we = 1'b0; re = 1'b0; clear_req = 1'b0;
            end
            #1;
            if (n0 == 0) begin
                checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL busy_rv0: got %b expected 0 (k=%0d)", rv0, k); end
                if (hold0_known) begin
                    checks++; if (dout0 !== exp_hold0) begin errors++; $display("FAIL busy_hold0: got %h expected %h (k=%0d)", dout0, exp_hold0, k); end
                end
            end
            @(posedge clk); #1;
            checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL busy_rv1: got %b expected 0 (k=%0d)", rv1, k); end
            checks++; if (err1 !== 1'b0 || err0 !== 1'b0) begin errors++; $display("FAIL busy_err: got %b/%b expected 0/0 (k=%0d)", err1, err0, k); end
            checks++; if (dout1 !== exp_dout1) begin errors++; $display("FAIL busy_hold1: got %h expected %h (k=%0d)", dout1, exp_dout1, k); end
            if (busy1 !== 1'b1 && n1 == 0) n1 = k;
            if (busy0 !== 1'b1 && n0 == 0) n0 = k;
            @(negedge clk);
        end
        we = 1'b0; re = 1'b0; clear_req = 1'b0;
    endtask

    task automatic test_reset();
        int n1, n0;
        reset = 1'b1; clear_req = 1'b0; we = 1'b0; re = 1'b0; addr = '0; din = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy1 !== 1'b1 || busy0 !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b/%b expected 1/1", busy1, busy0); end
        checks++; if (rv1 !== 1'b0 || rv0 !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b/%b expected 0/0", rv1, rv0); end
        checks++; if (err1 !== 1'b0 || err0 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b/%b expected 0/0", err1, err0); end
        checks++; if (dout1 !== 10'h000) begin errors++; $display("FAIL reset_dout1: got %h expected 000", dout1); end
        exp_dout1 = '0; hold0_known = 1'b0;
        model_clear();
        reset = 1'b0;
        run_clear(n1, n0);
        checks++; if (n1 != D1) begin errors++; $display("FAIL reset_clear_len1: got %0d expected %0d", n1, D1); end
        checks++; if (n0 != D0) begin errors++; $display("FAIL reset_clear_len0: got %0d expected %0d", n0, D0); end
    endtask

    task automatic test_clear_contents();
        for (int a = 0; a < D1; a++) begin
            drive(1'b0, 1'b1, a, 10'h000, 1'b0);
            checks++; if (dout0 !== exp_dout0c) begin errors++; $display("FAIL clear_dout0: addr %0d got %h expected %h", a, dout0, exp_dout0c); end
            @(posedge clk); #1;
            checks++; if (dout1 !== 10'h000 || rv1 !== 1'b1) begin errors++; $display("FAIL clear_dout1: addr %0d got %h/%b expected 000/1", a, dout1, rv1); end
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b0, 5, 10'h3A5, 1'b0);
        @(posedge clk); #1;
        checks++; if (rv1 !== 1'b0 || err1 !== 1'b0 || err0 !== 1'b0) begin errors++; $display("FAIL wr_flags: got rv=%b err=%b/%b expected 0 0/0", rv1, err1, err0); end
        drive(1'b0, 1'b1, 5, 10'h000, 1'b0);
        checks++; if (dout0 !== 10'h3A5 || rv0 !== 1'b1) begin errors++; $display("FAIL rd_comb: got %h/%b expected 3a5/1", dout0, rv0); end
        @(posedge clk); #1;
        checks++; if (dout1 !== 10'h3A5 || rv1 !== 1'b1) begin errors++; $display("FAIL rd_reg: got %h/%b expected 3a5/1", dout1, rv1); end
        drive(1'b0, 1'b0, 0, 10'h000, 1'b0);
        @(posedge clk); #1;
        checks++; if (rv1 !== 1'b0 || dout1 !== 10'h3A5) begin errors++; $display("FAIL rd_pulse: got %h/%b expected 3a5/0", dout1, rv1); end
    endtask

    task automatic test_same_cycle();
        drive(1'b1, 1'b0, 7, 10'h2AA, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 7, 10'h155, 1'b0);
        checks++; if (dout0 !== 10'h2AA) begin errors++; $display("FAIL rw_comb_old: got %h expected 2aa", dout0); end
        @(posedge clk); #1;
        checks++; if (dout1 !== 10'h2AA || rv1 !== 1'b1) begin errors++; $display("FAIL rw_reg_old: got %h/%b expected 2aa/1", dout1, rv1); end
        drive(1'b0, 1'b1, 7, 10'h000, 1'b0);
        checks++; if (dout0 !== 10'h155) begin errors++; $display("FAIL rw_comb_new: got %h expected 155", dout0); end
        @(posedge clk); #1;
        checks++; if (dout1 !== 10'h155) begin errors++; $display("FAIL rw_reg_new: got %h expected 155", dout1); end
    endtask

    task automatic test_clear_req();
        int n1, n0;
        drive(1'b1, 1'b0, 9, 10'h123, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 9, 10'h0FF, 1'b1);
        checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL clrreq_rv0: got %b expected 0", rv0); end
        @(posedge clk); #1;
        checks++; if (busy1 !== 1'b1 || busy0 !== 1'b1) begin errors++; $display("FAIL clrreq_busy: got %b/%b expected 1/1", busy1, busy0); end
        checks++; if (rv1 !== 1'b0 || err1 !== 1'b0 || err0 !== 1'b0) begin errors++; $display("FAIL clrreq_drop: got rv=%b err=%b/%b expected 0 0/0", rv1, err1, err0); end
        @(negedge clk);
        run_clear(n1, n0);
        checks++; if (n1 != D1 || n0 != D0) begin errors++; $display("FAIL clrreq_len: got %0d/%0d expected %0d/%0d", n1, n0, D1, D0); end
        drive(1'b0, 1'b1, 9, 10'h000, 1'b0);
        checks++; if (dout0 !== CV0) begin errors++; $display("FAIL clrreq_rd0: got %h expected %h", dout0, CV0); end
        @(posedge clk); #1;
        checks++; if (dout1 !== 10'h000) begin errors++; $display("FAIL clrreq_rd1: got %h expected 000", dout1); end
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 1'b0, 10, 10'h0F0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1010, 10'h2F0, 1'b0);
        @(posedge clk); #1;
        checks++; if (err0 !== 1'b1 || err1 !== 1'b0) begin errors++; $display("FAIL oor_wr_err: got %b/%b expected 0/1", err1, err0); end
        drive(1'b0, 1'b0, 0, 10'h000, 1'b0);
        @(posedge clk); #1;
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL oor_err_pulse: got %b expected 0", err0); end
        drive(1'b0, 1'b1, 10, 10'h000, 1'b0);
        checks++; if (dout0 !== 10'h0F0) begin errors++; $display("FAIL oor_no_alias: got %h expected 0f0", dout0); end
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1010, 10'h000, 1'b0);
        checks++; if (dout0 !== CV0 || rv0 !== 1'b1) begin errors++; $display("FAIL oor_rd_comb: got %h/%b expected %h/1", dout0, rv0, CV0); end
        @(posedge clk); #1;
        checks++; if (err0 !== 1'b1 || dout1 !== 10'h2F0) begin errors++; $display("FAIL oor_rd_err: got err0=%b dout1=%h expected 1 2f0", err0, dout1); end
    endtask

    task automatic test_reset_mid_clear();
        int n1, n0;
        drive(1'b0, 1'b0, 0, 10'h000, 1'b1);
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0; clear_req = 1'b0;
        repeat (500) @(negedge clk);
        reset = 1'b1;
        #1;
        exp_dout1 = '0; hold0_known = 1'b0;
        checks++; if (busy1 !== 1'b1 || busy0 !== 1'b1 || rv1 !== 1'b0 || err1 !== 1'b0 || err0 !== 1'b0 || dout1 !== 10'h000) begin
            errors++; $display("FAIL midreset_state: got busy=%b/%b rv1=%b err=%b/%b dout1=%h expected 1/1 0 0/0 000", busy1, busy0, rv1, err1, err0, dout1);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_clear(n1, n0);
        checks++; if (n1 != D1 || n0 != D0) begin errors++; $display("FAIL midreset_len: got %0d/%0d expected %0d/%0d", n1, n0, D1, D0); end
        drive(1'b1, 1'b0, 5, 10'h3A5, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 5, 10'h000, 1'b0);
        checks++; if (dout0 !== 10'h3A5 || rv0 !== 1'b1) begin errors++; $display("FAIL midreset_rd0: got %h/%b expected 3a5/1", dout0, rv0); end
        @(posedge clk); #1;
        checks++; if (dout1 !== 10'h3A5) begin errors++; $display("FAIL midreset_rd1: got %h expected 3a5", dout1); end
    endtask

    task automatic test_random();
        int a;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(990, 1023));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 10'($urandom), 1'b0);
            checks++; if (dout0 !== exp_dout0c || rv0 !== exp_rv0c) begin errors++; $display("FAIL rand_comb0: i=%0d addr %0d got %h/%b expected %h/%b", i, a, dout0, rv0, exp_dout0c, exp_rv0c); end
            @(posedge clk); #1;
            checks++; if (dout1 !== exp_dout1 || rv1 !== exp_rv1) begin errors++; $display("FAIL rand_reg1: i=%0d addr %0d got %h/%b expected %h/%b", i, a, dout1, rv1, exp_dout1, exp_rv1); end
            checks++; if (err1 !== exp_err1 || err0 !== exp_err0) begin errors++; $display("FAIL rand_err: i=%0d addr %0d got %b/%b expected %b/%b", i, a, err1, err0, exp_err1, exp_err0); end
            checks++; if (busy1 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL rand_busy: i=%0d got %b/%b expected 0/0", i, busy1, busy0); end
        end
    endtask

    initial begin
        test_reset();
        test_clear_contents();
        test_write_read();
        test_same_cycle();
        test_clear_req();
        test_out_of_range();
        test_reset_mid_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
